// File: rtl/decimal_entry_pkg.sv
// Shared key codes, digit width and entry FSM states for the decimal entry editor.
package decimal_entry_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [3:0] {
        KEY_DIGIT_0 = 4'h0,
        KEY_DIGIT_9 = 4'h9,
        KEY_BKSP    = 4'hA,
        KEY_CLEAR   = 4'hB,
        KEY_COMMIT  = 4'hC,
        KEY_CANCEL  = 4'hD
    } key_code_e;

    typedef enum logic [1:0] {
        ENTRY_EDIT,
        ENTRY_CONVERT,
        ENTRY_CLAMP
    } entry_state_e;

    function automatic logic is_digit_key(input logic [3:0] code);
        return code <= KEY_DIGIT_9;
    endfunction

endpackage

// File: rtl/decimal_entry_mul10_add.sv
// One decimal accumulate step: out = acc*10 + digit, built from two shifts.
module mul10_add #(
    parameter int W_ACC = 14
) (
    input  logic [W_ACC-1:0] acc,
    input  logic [3:0]       digit,
    output logic [W_ACC-1:0] sum
);

    assign sum = (acc << 3) + (acc << 1) + W_ACC'(digit);

endmodule

// File: rtl/decimal_entry.sv
// Keypad decimal editor: collects digits, converts MSB-first on commit and
// presents a clamped binary option value with a one-cycle valid pulse.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int W_OUT   = 8,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 99,
    parameter int W_ACC   = 14
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    output logic                             busy,
    output logic [DIGITS-1:0][DIGIT_W-1:0]   digits_out,
    output logic [2:0]                       digit_count,
    output logic [W_OUT-1:0]                 value_out,
    output logic                             value_valid,
    output logic                             clamped,
    output logic                             cancelled
);

    entry_state_e                  state, state_nxt;
    logic [DIGITS-1:0][DIGIT_W-1:0] digits;
    logic [2:0]                    count;
    logic [2:0]                    idx;
    logic [W_ACC-1:0]              acc;
    logic [W_ACC-1:0]              acc_step;
    logic [W_ACC-1:0]              clamp_in;
    logic [W_OUT:0]                clamp_res;
    logic [DIGIT_W-1:0]            cur_digit;
    logic                          key_acc;
    logic                          commit_go;

    // Result is {hit_bound, value}; compared at full accumulator width.
    function automatic logic [W_OUT:0] clamp_acc(input logic [W_ACC-1:0] a);
        if (a < W_ACC'(MIN_VAL))
            return {1'b1, W_OUT'(MIN_VAL)};
        else if (a > W_ACC'(MAX_VAL))
            return {1'b1, W_OUT'(MAX_VAL)};
        return {1'b0, a[W_OUT-1:0]};
    endfunction

    assign key_acc   = key_valid && (state == ENTRY_EDIT);
    assign commit_go = key_acc && (key_code == KEY_COMMIT);

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == 3'(i))
                cur_digit = digits[i];
    end

    mul10_add #(.W_ACC(W_ACC)) u_mul10_add (
        .acc   (acc),
        .digit (cur_digit),
        .sum   (acc_step)
    );

    // The last conversion step is clamped directly so the result is visible in CLAMP.
    assign clamp_in  = (state == ENTRY_CONVERT) ? acc_step : '0;
    assign clamp_res = clamp_acc(clamp_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ENTRY_EDIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENTRY_EDIT:
                if (commit_go)
                    state_nxt = (count == 3'd0) ? ENTRY_CLAMP : ENTRY_CONVERT;
            ENTRY_CONVERT:
                if (idx == 3'd0)
                    state_nxt = ENTRY_CLAMP;
            ENTRY_CLAMP:
                state_nxt = ENTRY_EDIT;
            default:
                state_nxt = ENTRY_EDIT;
        endcase
    end

    always_comb begin
        busy        = (state != ENTRY_EDIT);
        digits_out  = digits;
        digit_count = count;
    end

    always_ff @(posedge clk) begin
        if (commit_go)
            acc <= '0;
        else if (state == ENTRY_CONVERT)
            acc <= acc_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            count       <= 3'd0;
            idx         <= 3'd0;
            value_out   <= W_OUT'(MIN_VAL);
            value_valid <= 1'b0;
            clamped     <= 1'b0;
            cancelled   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            cancelled   <= 1'b0;
            case (state)
                ENTRY_EDIT: begin
                    if (key_acc) begin
                        if (is_digit_key(key_code)) begin
                            if (count < 3'(DIGITS)) begin
                                for (int i = DIGITS - 1; i > 0; i--)
                                    digits[i] <= digits[i-1];
                                digits[0] <= key_code;
                                count     <= count + 3'd1;
                            end
                        end else if (key_code == KEY_BKSP) begin
                            if (count != 3'd0) begin
                                for (int i = 0; i < DIGITS - 1; i++)
                                    digits[i] <= digits[i+1];
                                digits[DIGITS-1] <= '0;
                                count            <= count - 3'd1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            digits <= '0;
                            count  <= 3'd0;
                        end else if (key_code == KEY_CANCEL) begin
                            digits    <= '0;
                            count     <= 3'd0;
                            cancelled <= 1'b1;
                        end else if (key_code == KEY_COMMIT) begin
                            idx <= count - 3'd1;
                            if (count == 3'd0) begin
                                value_out   <= clamp_res[W_OUT-1:0];
                                clamped     <= clamp_res[W_OUT];
                                value_valid <= 1'b1;
                            end
                        end
                    end
                end
                ENTRY_CONVERT: begin
                    idx <= idx - 3'd1;
                    if (idx == 3'd0) begin
                        value_out   <= clamp_res[W_OUT-1:0];
                        clamped     <= clamp_res[W_OUT];
                        value_valid <= 1'b1;
                        digits      <= '0;
                        count       <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Randomised and directed bench for decimal_entry against a digit-queue reference model.
module tb_decimal_entry;

    localparam logic [3:0] K_BKSP   = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_COMMIT = 4'hC;
    localparam logic [3:0] K_CANCEL = 4'hD;
    localparam int MIN_V = 1;
    localparam int MAX_V = 21;
    localparam int NDIG  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             busy;
    logic [1:0][3:0]  digits_out;
    logic [2:0]       digit_count;
    logic [7:0]       value_out;
    logic             value_valid;
    logic             clamped;
    logic             cancelled;

    int vectors = 0;
    int miscompares = 0;

    // reference model: digits in entry order, plus the last committed result
    int   q[$];
    int   m_val = MIN_V;
    logic m_clp = 1'b0;

    always #5 clk = ~clk;

    decimal_entry #(
        .DIGITS(NDIG), .W_OUT(8), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .W_ACC(14)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .busy(busy), .digits_out(digits_out), .digit_count(digit_count),
        .value_out(value_out), .value_valid(value_valid), .clamped(clamped),
        .cancelled(cancelled)
    );

    function automatic logic [1:0][3:0] exp_digits();
        logic [1:0][3:0] d = '0;
        for (int i = 0; i < q.size(); i++)
            d[i] = 4'(q[q.size() - 1 - i]);
        return d;
    endfunction

    function automatic int model_number();
        int n = 0;
        foreach (q[i]) n = n * 10 + q[i];
        return n;
    endfunction

    function automatic int model_clamp(input int n);
        return (n < MIN_V) ? MIN_V : (n > MAX_V) ? MAX_V : n;
    endfunction

    // Applies one key; called and returning on a falling edge.
    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic model_key(input logic [3:0] code, output logic exp_cancel);
        exp_cancel = 1'b0;
        if (code <= 4'd9) begin
            if (q.size() < NDIG) q.push_back(int'(code));
        end else if (code == K_BKSP) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (code == K_CLEAR) begin
            q.delete();
        end else if (code == K_CANCEL) begin
            q.delete();
            exp_cancel = 1'b1;
        end
    endtask

    task automatic commit_and_wait(output int lat, output logic [7:0] val, output logic clp,
                                   output logic [2:0] dc, output logic busy_all,
                                   output logic post_valid, output logic post_busy);
        press(K_COMMIT);
        lat = 1;
        busy_all = 1'b1;
        while (value_valid !== 1'b1 && lat < 12) begin
            if (busy !== 1'b1) busy_all = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_all = 1'b0;
        val = value_out;
        clp = clamped;
        dc  = digit_count;
        @(negedge clk);
        post_valid = value_valid;
        post_busy  = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, digit_count, digits_out, value_out, value_valid, clamped, cancelled} !==
            {1'b0, 3'd0, 8'h00, 8'(MIN_V), 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b cnt=%0d dig=%h val=%0d vv=%b clp=%b can=%b",
                     busy, digit_count, digits_out, value_out, value_valid, clamped, cancelled);
        end
    endtask

    task automatic test_convert();
        int lat; logic [7:0] v; logic c, ba, pv, pb; logic [2:0] dc;
        q.delete();
        press(4'd1); press(4'd5);
        commit_and_wait(lat, v, c, dc, ba, pv, pb);
        vectors++;
        if (lat !== 3 || v !== 8'd15 || c !== 1'b0 || dc !== 3'd0 || ba !== 1'b1) begin
            miscompares++;
            $display("FAIL convert_15: lat=%0d val=%0d clp=%b cnt=%0d busy_ok=%b want lat=3 val=15 clp=0 cnt=0 busy_ok=1",
                     lat, v, c, dc, ba);
        end
        vectors++;
        if (pv !== 1'b0 || pb !== 1'b0) begin
            miscompares++;
            $display("FAIL convert_after: valid=%b busy=%b want 0 0", pv, pb);
        end
        m_val = 15; m_clp = 1'b0;
    endtask

    task automatic test_clamp();
        int lat; logic [7:0] v; logic c, ba, pv, pb; logic [2:0] dc;
        press(4'd9); press(4'd9);
        commit_and_wait(lat, v, c, dc, ba, pv, pb);
        vectors++;
        if (lat !== 3 || v !== 8'd21 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_high: lat=%0d val=%0d clp=%b want 3 21 1", lat, v, c);
        end
        press(4'd0);
        commit_and_wait(lat, v, c, dc, ba, pv, pb);
        vectors++;
        if (lat !== 2 || v !== 8'd1 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_low: lat=%0d val=%0d clp=%b want 2 1 1", lat, v, c);
        end
        commit_and_wait(lat, v, c, dc, ba, pv, pb);
        vectors++;
        if (lat !== 1 || v !== 8'd1 || c !== 1'b1 || ba !== 1'b1 || pb !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_commit: lat=%0d val=%0d clp=%b busy_ok=%b post_busy=%b want 1 1 1 1 0",
                     lat, v, c, ba, pb);
        end
        m_val = 1; m_clp = 1'b1;
    endtask

    task automatic test_edit();
        int lat; logic [7:0] v; logic c, ba, pv, pb; logic [2:0] dc;
        press(4'd1); press(4'd2);
        press(K_BKSP);
        vectors++;
        if (digit_count !== 3'd1 || digits_out !== {4'd0, 4'd1}) begin
            miscompares++;
            $display("FAIL backspace: cnt=%0d dig=%h want 1 01", digit_count, digits_out);
        end
        press(4'd7);
        vectors++;
        if (digit_count !== 3'd2 || digits_out !== {4'd1, 4'd7}) begin
            miscompares++;
            $display("FAIL edit_digits: cnt=%0d dig=%h want 2 17", digit_count, digits_out);
        end
        press(4'd3);
        vectors++;
        if (digit_count !== 3'd2 || digits_out !== {4'd1, 4'd7}) begin
            miscompares++;
            $display("FAIL full_buffer: cnt=%0d dig=%h want 2 17", digit_count, digits_out);
        end
        press(4'hE); press(4'hF);
        vectors++;
        if (digit_count !== 3'd2 || digits_out !== {4'd1, 4'd7} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL undefined_key: cnt=%0d dig=%h busy=%b want 2 17 0", digit_count, digits_out, busy);
        end
        commit_and_wait(lat, v, c, dc, ba, pv, pb);
        vectors++;
        if (lat !== 3 || v !== 8'd17 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_17: lat=%0d val=%0d clp=%b want 3 17 0", lat, v, c);
        end
        m_val = 17; m_clp = 1'b0;
    endtask

    task automatic test_cancel();
        int seen_valid = 0;
        press(4'd4);
        press(K_CANCEL);
        vectors++;
        if (cancelled !== 1'b1 || digit_count !== 3'd0 || digits_out !== 8'h00 ||
            value_out !== 8'd17 || value_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel: can=%b cnt=%0d dig=%h val=%0d vv=%b want 1 0 00 17 0",
                     cancelled, digit_count, digits_out, value_out, value_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (value_valid === 1'b1 || cancelled === 1'b1) seen_valid++;
        end
        vectors++;
        if (seen_valid !== 0 || value_out !== 8'd17 || clamped !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_after: stray_pulses=%0d val=%0d clp=%b want 0 17 0",
                     seen_valid, value_out, clamped);
        end
    endtask

    task automatic test_busy_drop();
        press(4'd2); press(4'd0);
        press(K_COMMIT);
        press(4'd5);
        press(4'd6);
        vectors++;
        if (value_valid !== 1'b1 || value_out !== 8'd20 || clamped !== 1'b0 || digit_count !== 3'd0) begin
            miscompares++;
            $display("FAIL busy_drop: vv=%b val=%0d clp=%b cnt=%0d want 1 20 0 0",
                     value_valid, value_out, clamped, digit_count);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || digit_count !== 3'd0 || digits_out !== 8'h00) begin
            miscompares++;
            $display("FAIL busy_drop_after: busy=%b cnt=%0d dig=%h want 0 0 00", busy, digit_count, digits_out);
        end
        m_val = 20; m_clp = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        press(4'd8); press(4'd8);
        press(K_COMMIT);
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, digit_count, digits_out, value_out, value_valid, clamped, cancelled} !==
            {1'b0, 3'd0, 8'h00, 8'(MIN_V), 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b cnt=%0d dig=%h val=%0d vv=%b clp=%b can=%b",
                     busy, digit_count, digits_out, value_out, value_valid, clamped, cancelled);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (value_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || value_out !== 8'(MIN_V) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: pulses=%0d val=%0d busy=%b want 0 %0d 0",
                     pulses, value_out, busy, MIN_V);
        end
        q.delete();
        m_val = MIN_V; m_clp = 1'b0;
    endtask

    task automatic test_random();
        int lat, n, r, exp_lat; logic [7:0] v; logic c, ba, pv, pb, ec; logic [2:0] dc;
        logic [3:0] code;
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 19));
            if (r < 11)       code = 4'($urandom_range(0, 9));
            else if (r < 13)  code = K_BKSP;
            else if (r == 13) code = K_CLEAR;
            else if (r == 14) code = K_CANCEL;
            else if (r == 15) code = 4'($urandom_range(14, 15));
            else              code = K_COMMIT;
            if (code == K_COMMIT) begin
                n = model_number();
                exp_lat = q.size() + 1;
                commit_and_wait(lat, v, c, dc, ba, pv, pb);
                m_val = model_clamp(n);
                m_clp = (n < MIN_V) || (n > MAX_V);
                q.delete();
                vectors++;
                if (lat !== exp_lat || v !== 8'(m_val) || c !== m_clp || dc !== 3'd0 ||
                    ba !== 1'b1 || pv !== 1'b0 || pb !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_commit[%0d]: lat=%0d val=%0d clp=%b cnt=%0d busy_ok=%b pv=%b pb=%b want lat=%0d val=%0d clp=%b",
                             it, lat, v, c, dc, ba, pv, pb, exp_lat, m_val, m_clp);
                end
            end else begin
                model_key(code, ec);
                press(code);
                vectors++;
                if (digit_count !== 3'(q.size()) || digits_out !== exp_digits() || cancelled !== ec ||
                    value_valid !== 1'b0 || value_out !== 8'(m_val) || clamped !== m_clp) begin
                    miscompares++;
                    $display("FAIL rand_key[%0d] code=%h: cnt=%0d dig=%h can=%b vv=%b val=%0d clp=%b want cnt=%0d dig=%h can=%b val=%0d clp=%b",
                             it, code, digit_count, digits_out, cancelled, value_valid, value_out, clamped,
                             q.size(), exp_digits(), ec, m_val, m_clp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_clamp();
        test_edit();
        test_cancel();
        test_busy_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
